spi_tx_byte_queue: RTL and testbench
====================================

Name: spi_tx_byte_queue

Overview:
- Upstream feeder for ice40_master_spi_controller.
- Buffers bytes from a producer in a synchronous FIFO.
- Drains the FIFO one byte at a time into the controller's tx_start/tx_data/tx_busy handshake.
- Provides flow control (full/level), flush, a start-timeout error and a sent-byte counter, so application logic never deals with controller busy/init phases.

Parameters:
- DEPTH, 16: FIFO entries; power of two, >= 2.
- START_TIMEOUT, 255: cycles to wait for tx_busy to rise after tx_start before abandoning the byte; >= 1.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- wr_en  in  1  push wr_data this cycle.
- wr_data  in  8  byte to enqueue.
- flush  in  1  discard all queued bytes.
- full  out  1  FIFO holds DEPTH entries.
- empty  out  1  FIFO holds 0 entries.
- level  out  $clog2(DEPTH)+1  current entry count.
- overflow  out  1  sticky: write attempted while full.
- timeout_err  out  1  sticky: START_TIMEOUT expired.
- clear_err  in  1  clears overflow and timeout_err.
- tx_busy  in  1  from controller; high during init and while a byte is in flight.
- tx_start  out  1  to controller; registered level request.
- tx_data  out  8  to controller; registered; stable while tx_start is high.
- sent_count  out  16  bytes accepted by the controller; wraps 0xFFFF->0.

Behaviour:
- Reset (reset=0, async) forces:
  - tx_start=0, tx_data=0
  - full=0, empty=1, level=0
  - overflow=0, timeout_err=0, sent_count=0
  - pointers=0, FSM=IDLE
- Write:
  - Stored when wr_en=1, not full and flush=0.
  - wr_en while full: byte dropped, overflow<=1.
  - Write and pop in the same cycle: both occur; level unchanged. At full this is still a drop, since full is evaluated before the pop.
- Flags: full/empty/level are registered and reflect state after the edge.
- FSM states:
  - IDLE: if !empty && !tx_busy && !flush -> START, with tx_data<=head and tx_start<=1, timer<=START_TIMEOUT-1. Head is not popped yet.
  - START:
    - If tx_busy=1 -> WAIT_DONE, with tx_start<=0, pop head, sent_count+1.
    - Else if timer==0 -> IDLE, with tx_start<=0, pop head (byte discarded), timeout_err<=1.
    - Else timer-1.
    - flush=1 -> IDLE, tx_start<=0, no count.
  - WAIT_DONE: tx_busy=0 -> IDLE. flush clears the FIFO but the in-flight byte completes.
- Latency: wr_en at edge N into an empty queue with tx_busy=0 gives tx_start=1 after edge N+1.
- Back-to-back: minimum one IDLE cycle between bytes. tx_start never goes high while tx_busy=1 in IDLE.
- Controller init: tx_busy high after controller reset holds the queue in IDLE; bytes accumulate.
- flush: pointers and level go to 0 next edge. flush wins over a simultaneous wr_en; that byte is discarded and overflow is not set.
- clear_err concurrent with a new error event: the set wins.

Decomposition:
- Package spi_queue_pkg:
  - FSM state encodings (IDLE, START, WAIT_DONE).
  - Byte width constant (8).
- Sub-module sync_byte_fifo (DEPTH param):
  - Ports: push/pop/flush, data in, head out, full/empty/level.
  - Storage in a register array; extra-bit pointers for the full/empty distinction.
- The drain FSM, timer, error flags and counter live in spi_tx_byte_queue.

Test Plan:
1. Reset, then hold tx_busy=1 for 10 cycles and write 0xA5,0x5A -> tx_start stays 0, level=2. Drop tx_busy -> tx_start=1 one edge later with tx_data=0xA5.
2. Controller mock raises tx_busy 2 cycles after tx_start and holds it 8 cycles; queue bytes 0x01..0x04 -> delivered in order 01,02,03,04. sent_count=4, empty=1, tx_start never high while tx_busy=1.
3. DEPTH=16, tx_busy=1, write 17 bytes -> full=1 after 16, level=16, overflow=1. The 17th byte is never transmitted. clear_err -> overflow=0.
4. START_TIMEOUT=4, mock never raises tx_busy, write 0x77 -> tx_start high exactly 4 cycles then 0, timeout_err=1, empty=1, sent_count=0.
5. Queue 0x10,0x20,0x30. Flush in WAIT_DONE of byte 0x10 -> 0x10 completes, sent_count=1, level=0 next edge, no further tx_start.
6. Assert reset mid-START with 3 bytes queued -> tx_start=0 immediately (async), level=0. After release with tx_busy=0: no tx_start.

Source files
------------

// File: rtl/spi_queue_pkg.sv
// Shared types and constants for the SPI transmit byte queue.
// Drain FSM encodings and the byte width.
package spi_queue_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_START     = 2'd1,
        S_WAIT_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/spi_tx_byte_queue_if.sv
// Handshake bundle between the byte queue and the SPI controller.
// master = queue side, slave = controller side.
interface spi_tx_byte_queue_if;
    import spi_queue_pkg::*;

    logic              tx_start;
    logic [BYTE_W-1:0] tx_data;
    logic              tx_busy;

    modport master (
        output tx_start,
        output tx_data,
        input  tx_busy
    );

    modport slave (
        input  tx_start,
        input  tx_data,
        output tx_busy
    );

endinterface

// File: rtl/sync_byte_fifo.sv
// Synchronous byte FIFO with extra-bit pointers.
// Flush resets both pointers and overrides push/pop.
module sync_byte_fifo
    import spi_queue_pkg::*;
#(
    parameter int DEPTH = 16
)(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [BYTE_W-1:0]          din,
    output logic [BYTE_W-1:0]          head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]       r_wp;
    logic [AW:0]       r_rp;
    logic [BYTE_W-1:0] r_mem [DEPTH];
    logic [AW:0]       w_level;
    logic              w_do_push;
    logic              w_do_pop;

    assign w_level   = r_wp - r_rp;
    assign level     = w_level;
    assign full      = (w_level == (AW+1)'(DEPTH));
    assign empty     = (r_wp == r_rp);
    assign head      = r_mem[r_rp[AW-1:0]];
    assign w_do_push = push && !full && !flush;
    assign w_do_pop  = pop && !empty && !flush;

    // Pointer update; flush empties the queue in one edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wp <= '0;
            r_rp <= '0;
        end else if (flush) begin
            r_wp <= '0;
            r_rp <= '0;
        end else begin
            if (w_do_push) r_wp <= r_wp + 1'b1;
            if (w_do_pop)  r_rp <= r_rp + 1'b1;
        end
    end

    // Storage array; contents need no reset since pointers gate reads.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wp[AW-1:0]] <= din;
    end

endmodule

// File: rtl/spi_tx_byte_queue.sv
// Byte queue feeding the SPI controller's start/busy handshake.
// Drain FSM, start timeout, sticky errors and sent counter.
module spi_tx_byte_queue
    import spi_queue_pkg::*;
#(
    parameter int DEPTH         = 16,
    parameter int START_TIMEOUT = 255
)(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_en,
    input  logic [BYTE_W-1:0]      wr_data,
    input  logic                   flush,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow,
    output logic                   timeout_err,
    input  logic                   clear_err,
    output logic [15:0]            sent_count,
    spi_tx_byte_queue_if.master    ctl
);

    localparam int TW =
        (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT) : 1;
    localparam logic [TW-1:0] TLOAD = TW'(START_TIMEOUT - 1);

    state_t            r_state;
    state_t            w_state_nx;
    logic [TW-1:0]     r_timer;
    logic [TW-1:0]     w_timer_nx;
    logic              r_tx_start;
    logic              w_tx_start_nx;
    logic [BYTE_W-1:0] r_tx_data;
    logic [BYTE_W-1:0] w_tx_data_nx;
    logic [15:0]       r_sent;
    logic              r_overflow;
    logic              r_timeout;
    logic              w_pop;
    logic              w_count;
    logic              w_to_set;
    logic              w_ovf_set;
    logic              w_push;
    logic [BYTE_W-1:0] w_head;
    logic              w_full;
    logic              w_empty;

    assign w_push    = wr_en && !w_full && !flush;
    assign w_ovf_set = wr_en && w_full && !flush;

    sync_byte_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_push),
        .pop   (w_pop),
        .flush (flush),
        .din   (wr_data),
        .head  (w_head),
        .full  (w_full),
        .empty (w_empty),
        .level (level)
    );

    assign full        = w_full;
    assign empty       = w_empty;
    assign overflow    = r_overflow;
    assign timeout_err = r_timeout;
    assign sent_count  = r_sent;
    assign ctl.tx_start = r_tx_start;
    assign ctl.tx_data  = r_tx_data;

    // Drain FSM next-state and registered-output decode.
    always_comb begin
        w_state_nx    = r_state;
        w_timer_nx    = r_timer;
        w_tx_start_nx = r_tx_start;
        w_tx_data_nx  = r_tx_data;
        w_pop         = 1'b0;
        w_count       = 1'b0;
        w_to_set      = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (!w_empty && !ctl.tx_busy && !flush) begin
                    w_state_nx    = S_START;
                    w_tx_data_nx  = w_head;
                    w_tx_start_nx = 1'b1;
                    w_timer_nx    = TLOAD;
                end
            end
            S_START: begin
                if (flush) begin
                    w_state_nx    = S_IDLE;
                    w_tx_start_nx = 1'b0;
                end else if (ctl.tx_busy) begin
                    w_state_nx    = S_WAIT_DONE;
                    w_tx_start_nx = 1'b0;
                    w_pop         = 1'b1;
                    w_count       = 1'b1;
                end else if (r_timer == '0) begin
                    w_state_nx    = S_IDLE;
                    w_tx_start_nx = 1'b0;
                    w_pop         = 1'b1;
                    w_to_set      = 1'b1;
                end else begin
                    w_timer_nx = r_timer - 1'b1;
                end
            end
            S_WAIT_DONE: begin
                if (!ctl.tx_busy) w_state_nx = S_IDLE;
            end
            default: begin
                w_state_nx    = S_IDLE;
                w_tx_start_nx = 1'b0;
            end
        endcase
    end

    // FSM state, handshake outputs, timer and sent counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_timer    <= '0;
            r_tx_start <= 1'b0;
            r_tx_data  <= '0;
            r_sent     <= '0;
        end else begin
            r_state    <= w_state_nx;
            r_timer    <= w_timer_nx;
            r_tx_start <= w_tx_start_nx;
            r_tx_data  <= w_tx_data_nx;
            if (w_count) r_sent <= r_sent + 16'd1;
        end
    end

    // Sticky error flags; a new event beats clear_err.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_overflow <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            if (w_ovf_set)      r_overflow <= 1'b1;
            else if (clear_err) r_overflow <= 1'b0;
            if (w_to_set)       r_timeout  <= 1'b1;
            else if (clear_err) r_timeout  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_spi_tx_byte_queue.sv
// Directed bench for spi_tx_byte_queue with a busy-handshake mock.
// Table-driven timeout sequence plus hand-written corner cases.
module tb_spi_tx_byte_queue;

    logic        clk;
    logic        reset;
    logic        wr_en;
    logic [7:0]  wr_data;
    logic        flush;
    logic        full;
    logic        empty;
    logic [4:0]  level;
    logic        overflow;
    logic        timeout_err;
    logic        clear_err;
    logic [15:0] sent_count;

    logic busy_main;
    logic busy_mock;
    logic mock_en;
    int   total;
    int   bad;
    int   viol;
    int   ph;
    int   hold;
    logic [7:0] got_q [$];

    spi_tx_byte_queue_if ctl ();

    assign ctl.tx_busy = mock_en ? busy_mock : busy_main;

    spi_tx_byte_queue #(
        .DEPTH         (16),
        .START_TIMEOUT (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .flush       (flush),
        .full        (full),
        .empty       (empty),
        .level       (level),
        .overflow    (overflow),
        .timeout_err (timeout_err),
        .clear_err   (clear_err),
        .sent_count  (sent_count),
        .ctl         (ctl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Controller mock: busy rises 2 cycles after tx_start, held 8 cycles.
    always begin
        @(posedge clk);
        #1;
        if (!mock_en) begin
            ph = 0;
            busy_mock = 1'b0;
        end else begin
            if (ctl.tx_start && ctl.tx_busy) viol++;
            case (ph)
                0: if (ctl.tx_start) begin
                    got_q.push_back(ctl.tx_data);
                    ph = 1;
                end
                1: begin
                    busy_mock = 1'b1;
                    hold = 8;
                    ph = 2;
                end
                default: begin
                    hold--;
                    if (hold == 0) begin
                        busy_mock = 1'b0;
                        ph = 0;
                    end
                end
            endcase
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        wr_en = 1'b0;
        flush = 1'b0;
        clear_err = 1'b0;
        mock_en = 1'b0;
        busy_main = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b1;
        got_q.delete();
        viol = 0;
    endtask

    typedef struct {
        logic       wr;
        logic [7:0] d;
        logic       ts;
        logic [7:0] td;
        int         lvl;
        logic       to;
    } vec_t;

    vec_t tv [7];
    logic seen;
    int   k;

    initial begin
        total = 0;
        bad = 0;
        viol = 0;
        ph = 0;
        hold = 0;
        busy_mock = 1'b0;
        wr_data = 8'h00;

        tv[0] = '{1'b1, 8'h77, 1'b0, 8'h00, 1, 1'b0};
        tv[1] = '{1'b0, 8'h00, 1'b1, 8'h77, 1, 1'b0};
        tv[2] = '{1'b0, 8'h00, 1'b1, 8'h77, 1, 1'b0};
        tv[3] = '{1'b0, 8'h00, 1'b1, 8'h77, 1, 1'b0};
        tv[4] = '{1'b0, 8'h00, 1'b1, 8'h77, 1, 1'b0};
        tv[5] = '{1'b0, 8'h00, 1'b0, 8'h77, 0, 1'b1};
        tv[6] = '{1'b0, 8'h00, 1'b0, 8'h77, 0, 1'b1};

        // 1: controller init holds the queue
        do_reset();
        chk("rst_start", 32'(ctl.tx_start), 0);
        chk("rst_data", 32'(ctl.tx_data), 0);
        chk("rst_full", 32'(full), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_level", 32'(level), 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_to", 32'(timeout_err), 0);
        chk("rst_sent", 32'(sent_count), 0);
        busy_main = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            wr_en = (i == 2 || i == 3);
            wr_data = (i == 2) ? 8'hA5 : 8'h5A;
            step();
            if (ctl.tx_start) seen = 1'b1;
        end
        chk("t1_hold", 32'(seen), 0);
        chk("t1_level", 32'(level), 2);
        busy_main = 1'b0;
        step();
        chk("t1_start", 32'(ctl.tx_start), 1);
        chk("t1_data", 32'(ctl.tx_data), 32'h A5);

        // 2: ordered delivery through the mock
        do_reset();
        mock_en = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            wr_en = 1'b1;
            wr_data = 8'(i);
            step();
        end
        wr_en = 1'b0;
        k = 0;
        while (!(sent_count == 4 && empty && !busy_mock) && k < 400) begin
            step();
            k++;
        end
        chk("t2_wait", 32'(k < 400), 1);
        repeat (4) step();
        chk("t2_n", 32'(got_q.size()), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < got_q.size())
                chk("t2_byte", 32'(got_q[i]), 32'(i + 1));
        end
        chk("t2_sent", 32'(sent_count), 4);
        chk("t2_empty", 32'(empty), 1);
        chk("t2_viol", 32'(viol), 0);

        // 3: overflow at DEPTH
        do_reset();
        busy_main = 1'b1;
        for (int i = 0; i < 17; i++) begin
            wr_en = 1'b1;
            wr_data = 8'(8'h80 + i);
            step();
            if (i == 15) chk("t3_full16", 32'(full), 1);
        end
        wr_en = 1'b0;
        chk("t3_level", 32'(level), 16);
        chk("t3_ovf", 32'(overflow), 1);
        clear_err = 1'b1;
        step();
        clear_err = 1'b0;
        chk("t3_clr", 32'(overflow), 0);
        mock_en = 1'b1;
        k = 0;
        while (!(sent_count == 16 && !busy_mock) && k < 1000) begin
            step();
            k++;
        end
        chk("t3_wait", 32'(k < 1000), 1);
        repeat (20) step();
        chk("t3_n", 32'(got_q.size()), 16);
        if (got_q.size() > 0)
            chk("t3_last", 32'(got_q[got_q.size() - 1]), 32'h8F);

        // 4: start timeout, cycle by cycle
        do_reset();
        for (int i = 0; i < 7; i++) begin
            wr_en = tv[i].wr;
            wr_data = tv[i].d;
            step();
            chk("t4_start", 32'(ctl.tx_start), 32'(tv[i].ts));
            chk("t4_data", 32'(ctl.tx_data), 32'(tv[i].td));
            chk("t4_level", 32'(level), 32'(tv[i].lvl));
            chk("t4_to", 32'(timeout_err), 32'(tv[i].to));
        end
        chk("t4_sent", 32'(sent_count), 0);
        chk("t4_empty", 32'(empty), 1);

        // 5: flush while a byte is in flight
        do_reset();
        mock_en = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            wr_en = 1'b1;
            wr_data = 8'(i * 16);
            step();
        end
        wr_en = 1'b0;
        k = 0;
        while (!busy_mock && k < 50) begin
            step();
            k++;
        end
        chk("t5_wait", 32'(k < 50), 1);
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("t5_level", 32'(level), 0);
        repeat (30) step();
        chk("t5_n", 32'(got_q.size()), 1);
        if (got_q.size() > 0)
            chk("t5_byte", 32'(got_q[0]), 32'h10);
        chk("t5_sent", 32'(sent_count), 1);
        chk("t5_start", 32'(ctl.tx_start), 0);

        // 6: async reset in START
        do_reset();
        busy_main = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wr_en = 1'b1;
            wr_data = 8'(8'hC0 + i);
            step();
        end
        wr_en = 1'b0;
        busy_main = 1'b0;
        step();
        chk("t6_pre", 32'(ctl.tx_start), 1);
        reset = 1'b0;
        #1;
        chk("t6_start", 32'(ctl.tx_start), 0);
        chk("t6_level", 32'(level), 0);
        step();
        reset = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (ctl.tx_start) seen = 1'b1;
        end
        chk("t6_quiet", 32'(seen), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
